bgpu_mem_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single SoC memory port between NumPorts requesters
//  (debug system-bus master, GPU compute-unit fetch/LSU ports). Forwards one request per

---
 rtl/bgpu_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_bgpu_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bgpu_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between several requesters.
// Requests are issued one per handshake, with grant locking while the memory stalls.
// Outstanding transactions are tracked in order, so each in-order memory response
// can be routed back to its originating port through a credit-limited response FIFO.
module bgpu_mem_arbiter #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPorts-1:0]               req_valid_i,
    output logic [NumPorts-1:0]               req_ready_o,
    input  logic [NumPorts*AddressWidth-1:0]  req_addr_i,
    input  logic [NumPorts-1:0]               req_we_i,
    input  logic [NumPorts*DataWidth-1:0]     req_wdata_i,
    input  logic [NumPorts*(DataWidth/8)-1:0] req_be_i,
    output logic [NumPorts-1:0]               rsp_valid_o,
    input  logic [NumPorts-1:0]               rsp_ready_i,
    output logic [DataWidth-1:0]              rsp_rdata_o,
    output logic                              mem_req_valid_o,
    input  logic                              mem_req_ready_i,
    output logic [AddressWidth-1:0]           mem_req_addr_o,
    output logic                              mem_req_we_o,
    output logic [DataWidth-1:0]              mem_req_wdata_o,
    output logic [(DataWidth/8)-1:0]          mem_req_be_o,
    input  logic                              mem_rsp_valid_i,
    input  logic [DataWidth-1:0]              mem_rsp_rdata_i
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned IdW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
    localparam logic [CntW:0] MaxCount = MaxOutstanding[CntW:0];

    typedef enum logic {StIdle, StLocked} state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      grant_q, grant_d;
    logic [IdW-1:0]      rrPtr_q, rrPtr_d;
    logic [CntW-1:0]     inflight_q, inflight_d;
    logic [CntW-1:0]     fifoCount_q, fifoCount_d;
    logic [PtrW-1:0]     idWrPtr_q, idWrPtr_d, idRdPtr_q, idRdPtr_d;
    logic [PtrW-1:0]     fifoWrPtr_q, fifoWrPtr_d, fifoRdPtr_q, fifoRdPtr_d;
    logic [IdW-1:0]      idQueue_q [MaxOutstanding];
    logic [IdW-1:0]      fifoId_q [MaxOutstanding];
    logic [DataWidth-1:0] fifoData_q [MaxOutstanding];

    logic                credit;
    logic                arbFound;
    logic [IdW-1:0]      arbGrant;
    int unsigned         idx;
    logic [IdW-1:0]      selGrant;
    logic                issue;
    logic                rspAccept;
    logic                rspPop;
    logic                fifoNotEmpty;
    logic [IdW-1:0]      headId;

    function automatic logic [IdW-1:0] nextPort(input logic [IdW-1:0] p);
        if (32'(p) == NumPorts - 1) return '0;
        return p + 1'b1;
    endfunction

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
        if (32'(p) == MaxOutstanding - 1) return '0;
        return p + 1'b1;
    endfunction

    // Credit uses registered counts only, so a response never frees a slot in the same cycle.
    assign credit = ({1'b0, inflight_q} + {1'b0, fifoCount_q}) < MaxCount;

    // Round-robin search: first valid port at or after the pointer, wrapping around.
    always_comb begin
        arbFound = 1'b0;
        arbGrant = '0;
        idx      = 0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            idx = 32'(rrPtr_q) + i;
            if (idx >= NumPorts) idx = idx - NumPorts;
            if (!arbFound && req_valid_i[idx]) begin
                arbFound = 1'b1;
                arbGrant = idx[IdW-1:0];
            end
        end
    end

    // Grant FSM: issue straight from IDLE, or hold the grant in LOCKED until accepted.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rrPtr_d         = rrPtr_q;
        selGrant        = arbGrant;
        mem_req_valid_o = 1'b0;
        case (state_q)
            StIdle: begin
                if (credit && arbFound) mem_req_valid_o = 1'b1;
            end
            StLocked: begin
                mem_req_valid_o = 1'b1;
                selGrant        = grant_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (rst_i) mem_req_valid_o = 1'b0;
        issue = mem_req_valid_o && mem_req_ready_i;
        if (issue) begin
            state_d = StIdle;
            rrPtr_d = nextPort(selGrant);
        end else if (mem_req_valid_o) begin
            state_d = StLocked;
            grant_d = selGrant;
        end
    end

    // Payload mux and per-port ready for the currently selected requester.
    always_comb begin
        req_ready_o     = '0;
        if (mem_req_valid_o) req_ready_o[selGrant] = mem_req_ready_i;
        mem_req_addr_o  = req_addr_i[32'(selGrant)*AddressWidth +: AddressWidth];
        mem_req_we_o    = req_we_i[selGrant];
        mem_req_wdata_o = req_wdata_i[32'(selGrant)*DataWidth +: DataWidth];
        mem_req_be_o    = req_be_i[32'(selGrant)*BeWidth +: BeWidth];
    end

    // Response side: accept memory responses into the FIFO, present the head to its port.
    always_comb begin
        rspAccept    = mem_rsp_valid_i && (inflight_q != '0);
        fifoNotEmpty = (fifoCount_q != '0);
        headId       = fifoId_q[fifoRdPtr_q];
        rspPop       = fifoNotEmpty && rsp_ready_i[headId];
        rsp_valid_o  = '0;
        if (fifoNotEmpty && !rst_i) rsp_valid_o[headId] = 1'b1;
        rsp_rdata_o  = fifoData_q[fifoRdPtr_q];
    end

    // Counter and pointer updates; simultaneous increment and decrement cancel out.
    always_comb begin
        inflight_d  = inflight_q;
        fifoCount_d = fifoCount_q;
        if (issue && !rspAccept) inflight_d = inflight_q + 1'b1;
        else if (!issue && rspAccept) inflight_d = inflight_q - 1'b1;
        if (rspAccept && !rspPop) fifoCount_d = fifoCount_q + 1'b1;
        else if (!rspAccept && rspPop) fifoCount_d = fifoCount_q - 1'b1;
        idWrPtr_d   = issue ? nextPtr(idWrPtr_q) : idWrPtr_q;
        idRdPtr_d   = rspAccept ? nextPtr(idRdPtr_q) : idRdPtr_q;
        fifoWrPtr_d = rspAccept ? nextPtr(fifoWrPtr_q) : fifoWrPtr_q;
        fifoRdPtr_d = rspPop ? nextPtr(fifoRdPtr_q) : fifoRdPtr_q;
    end

    // Control state register with synchronous reset; in-flight work is simply forgotten.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rrPtr_q     <= '0;
            inflight_q  <= '0;
            fifoCount_q <= '0;
            idWrPtr_q   <= '0;
            idRdPtr_q   <= '0;
            fifoWrPtr_q <= '0;
            fifoRdPtr_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rrPtr_q     <= rrPtr_d;
            inflight_q  <= inflight_d;
            fifoCount_q <= fifoCount_d;
            idWrPtr_q   <= idWrPtr_d;
            idRdPtr_q   <= idRdPtr_d;
            fifoWrPtr_q <= fifoWrPtr_d;
            fifoRdPtr_q <= fifoRdPtr_d;
        end
    end

    // Storage arrays need no reset: their valid range is defined by the pointers.
    always_ff @(posedge clk_i) begin
        if (issue) idQueue_q[idWrPtr_q] <= selGrant;
        if (rspAccept) begin
            fifoId_q[fifoWrPtr_q]   <= idQueue_q[idRdPtr_q];
            fifoData_q[fifoWrPtr_q] <= mem_rsp_rdata_i;
        end
    end

    // A response with nothing outstanding means the memory and arbiter disagree.
    rspWithoutRequest: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rsp_valid_i |-> (inflight_q != '0));

endmodule

// File: tb/tb_bgpu_mem_arbiter.sv
// Directed testbench for bgpu_mem_arbiter with two ports and four outstanding credits.
module tb_bgpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [63:0] reqAddr;
    logic [1:0]  reqWe;
    logic [63:0] reqWdata;
    logic [7:0]  reqBe;
    logic [1:0]  rspValid;
    logic [1:0]  rspReady;
    logic [31:0] rspRdata;
    logic        memReqValid;
    logic        memReqReady;
    logic [31:0] memReqAddr;
    logic        memReqWe;
    logic [31:0] memReqWdata;
    logic [3:0]  memReqBe;
    logic        memRspValid;
    logic [31:0] memRspRdata;
    int          checks = 0;
    int          errors = 0;

    bgpu_mem_arbiter dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (reqValid),
        .req_ready_o     (reqReady),
        .req_addr_i      (reqAddr),
        .req_we_i        (reqWe),
        .req_wdata_i     (reqWdata),
        .req_be_i        (reqBe),
        .rsp_valid_o     (rspValid),
        .rsp_ready_i     (rspReady),
        .rsp_rdata_o     (rspRdata),
        .mem_req_valid_o (memReqValid),
        .mem_req_ready_i (memReqReady),
        .mem_req_addr_o  (memReqAddr),
        .mem_req_we_o    (memReqWe),
        .mem_req_wdata_o (memReqWdata),
        .mem_req_be_o    (memReqBe),
        .mem_rsp_valid_i (memRspValid),
        .mem_rsp_rdata_i (memRspRdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic memReady,
                                 input logic rspIn, input logic [31:0] rdata,
                                 input logic [1:0] rspRdy);
        reqValid    = valid;
        memReqReady = memReady;
        memRspValid = rspIn;
        memRspRdata = rdata;
        rspReady    = rspRdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst      = 1'b1;
        reqAddr  = {32'h0000_2000, 32'h0000_0100};
        reqWe    = 2'b00;
        reqWdata = {32'h5555_AAAA, 32'h1111_2222};
        reqBe    = 8'hFF;
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 2'b11);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("reset_mem_valid", 64'(memReqValid), 64'd0);
        checkOutput("reset_req_ready", 64'(reqReady), 64'd0);
        checkOutput("reset_rsp_valid", 64'(rspValid), 64'd0);
        memReqBe = memReqBe;

        // single read from port 0, response two cycles after the handshake
        $display("[TB] single read");
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t1_mem_valid", 64'(memReqValid), 64'd1);
        checkOutput("t1_addr", 64'(memReqAddr), 64'h100);
        checkOutput("t1_req_ready", 64'(reqReady), 64'b01);
        checkOutput("t1_we", 64'(memReqWe), 64'd0);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t1_idle_after", 64'(memReqValid), 64'd0);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b11);
        checkOutput("t1_not_fallthrough", 64'(rspValid), 64'b00);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t1_rsp_valid", 64'(rspValid), 64'b01);
        checkOutput("t1_rsp_data", 64'(rspRdata), 64'hDEAD_BEEF);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t1_rsp_drained", 64'(rspValid), 64'b00);

        // both ports continuously valid: pointer sits at 1, so grants go 1,0,1,0...
        $display("[TB] alternating grants");
        reqAddr = {32'h0000_2000, 32'h0000_1000};
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k < 8) ? 2'b11 : 2'b00, 1'b1, (k >= 1 && k <= 8),
                          32'hA0 + 32'(k) - 32'd1, 2'b11);
            if (k < 8) begin
                checkOutput("t2_grant", 64'(reqReady), (k % 2 == 0) ? 64'b10 : 64'b01);
                checkOutput("t2_addr", 64'(memReqAddr),
                            (k % 2 == 0) ? 64'h2000 : 64'h1000);
            end
            if (k >= 2) begin
                checkOutput("t2_rsp_port", 64'(rspValid),
                            ((k - 2) % 2 == 0) ? 64'b10 : 64'b01);
                checkOutput("t2_rsp_data", 64'(rspRdata), 64'hA0 + 64'(k) - 64'd2);
            end
            tick();
        end
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t2_drained", 64'(rspValid), 64'b00);

        // port 1 granted while memory stalls; port 0 must not steal the grant
        $display("[TB] locked grant");
        reqWe = 2'b10;
        applyStimulus(2'b10, 1'b0, 1'b0, 32'h0, 2'b11);
        checkOutput("t3_valid", 64'(memReqValid), 64'd1);
        checkOutput("t3_addr0", 64'(memReqAddr), 64'h2000);
        checkOutput("t3_ready0", 64'(reqReady), 64'b00);
        tick();
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h0, 2'b11);
        checkOutput("t3_addr1", 64'(memReqAddr), 64'h2000);
        checkOutput("t3_we1", 64'(memReqWe), 64'd1);
        checkOutput("t3_ready1", 64'(reqReady), 64'b00);
        tick();
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h0, 2'b11);
        checkOutput("t3_wdata2", 64'(memReqWdata), 64'h5555_AAAA);
        checkOutput("t3_addr2", 64'(memReqAddr), 64'h2000);
        tick();
        applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t3_accept1", 64'(reqReady), 64'b10);
        checkOutput("t3_addr3", 64'(memReqAddr), 64'h2000);
        tick();
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t3_accept0", 64'(reqReady), 64'b01);
        checkOutput("t3_addr4", 64'(memReqAddr), 64'h1000);
        checkOutput("t3_we4", 64'(memReqWe), 64'd0);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b1, 32'h11, 2'b11);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b1, 32'h22, 2'b11);
        checkOutput("t3_rsp_port1", 64'(rspValid), 64'b10);
        checkOutput("t3_rsp_data1", 64'(rspRdata), 64'h11);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t3_rsp_port0", 64'(rspValid), 64'b01);
        checkOutput("t3_rsp_data0", 64'(rspRdata), 64'h22);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t3_drained", 64'(rspValid), 64'b00);
        reqWe = 2'b00;

        // credit limit: four handshakes, then stall until a response leaves the FIFO
        $display("[TB] credit limit");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
            checkOutput("t4_issue", 64'(memReqValid), (k < 4) ? 64'd1 : 64'd0);
            tick();
        end
        applyStimulus(2'b01, 1'b1, 1'b1, 32'h44, 2'b11);
        checkOutput("t4_no_same_cycle_credit", 64'(memReqValid), 64'd0);
        tick();
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t4_fifo_holds_credit", 64'(memReqValid), 64'd0);
        checkOutput("t4_rsp_valid", 64'(rspValid), 64'b01);
        checkOutput("t4_rsp_data", 64'(rspRdata), 64'h44);
        tick();
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t4_slot_freed", 64'(memReqValid), 64'd1);
        tick();
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t4_full_again", 64'(memReqValid), 64'd0);
        tick();

        // reset with transactions in flight and a buffered response
        $display("[TB] reset mid-operation");
        applyStimulus(2'b00, 1'b1, 1'b1, 32'h99, 2'b00);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b00);
        checkOutput("t6_buffered", 64'(rspValid), 64'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b00);
        checkOutput("t6_rsp_cleared", 64'(rspValid), 64'b00);
        checkOutput("t6_mem_valid", 64'(memReqValid), 64'd0);
        checkOutput("t6_req_ready", 64'(reqReady), 64'b00);
        applyStimulus(2'b10, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t6_fresh_grant", 64'(reqReady), 64'b10);
        checkOutput("t6_fresh_addr", 64'(memReqAddr), 64'h2000);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b1, 32'h77, 2'b11);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t6_fresh_rsp", 64'(rspValid), 64'b10);
        checkOutput("t6_fresh_data", 64'(rspRdata), 64'h77);
        tick();

        // head-of-line blocking: port 0 not ready holds port 1 behind it
        $display("[TB] head-of-line");
        applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b10);
        checkOutput("t5_grant0", 64'(reqReady), 64'b01);
        tick();
        applyStimulus(2'b11, 1'b1, 1'b0, 32'h0, 2'b10);
        checkOutput("t5_grant1", 64'(reqReady), 64'b10);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b1, 32'hB0, 2'b10);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b1, 32'hB1, 2'b10);
        checkOutput("t5_head_a", 64'(rspValid), 64'b01);
        checkOutput("t5_head_data_a", 64'(rspRdata), 64'hB0);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b10);
        checkOutput("t5_head_b", 64'(rspValid), 64'b01);
        checkOutput("t5_head_data_b", 64'(rspRdata), 64'hB0);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t5_release", 64'(rspValid), 64'b01);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t5_second", 64'(rspValid), 64'b10);
        checkOutput("t5_second_data", 64'(rspRdata), 64'hB1);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
        checkOutput("t5_drained", 64'(rspValid), 64'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
